// File: rtl/switch_rr_arbiter_if.sv
// Request, backpressure and grant bundle between the switch allocator and the
// per-output round-robin arbiters of the 4-port crossbar (bit order L,N,E,S).
interface switch_rr_arbiter_if;
  logic [3:0] req_L;
  logic [3:0] req_N;
  logic [3:0] req_E;
  logic [3:0] req_S;
  logic       N_full;
  logic       E_full;
  logic       S_full;
  logic [3:0] L_arb_res;
  logic [3:0] N_arb_res;
  logic [3:0] E_arb_res;
  logic [3:0] S_arb_res;

  modport master (
    output req_L, req_N, req_E, req_S,
    output N_full, E_full, S_full,
    input  L_arb_res, N_arb_res, E_arb_res, S_arb_res
  );

  modport slave (
    input  req_L, req_N, req_E, req_S,
    input  N_full, E_full, S_full,
    output L_arb_res, N_arb_res, E_arb_res, S_arb_res
  );
endinterface

// File: rtl/switch_rr_arbiter.sv
// Bank of four independent round-robin arbiters (outputs L,N,E,S) with
// grant hold under downstream backpressure and registered one-hot selects.
module switch_rr_arbiter #(
  parameter int         NREQ    = 4,
  parameter logic [1:0] RST_PTR = 2'd3
) (
  input  logic               clk,
  input  logic               rst,
  switch_rr_arbiter_if.slave arb
);

  // Array slot n serves output n: 0=L, 1=N, 2=E, 3=S.
  logic [3:0] req_s     [4];
  logic       full_s    [4];
  logic [3:0] g_r       [4];
  logic [1:0] ptr_r     [4];
  logic [3:0] g_nxt_s   [4];
  logic [1:0] ptr_nxt_s [4];

  // Scan from index p downwards with wrap; the first request found wins.
  function automatic logic [3:0] rr_pick(input logic [3:0] req, input logic [1:0] p);
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       found;
    gnt   = 4'b0000;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = p - k[1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end else begin
        gnt = gnt;
      end
    end
    return gnt;
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] g);
    logic [1:0] idx;
    case (g)
      4'b1000: idx = 2'd3;
      4'b0100: idx = 2'd2;
      4'b0010: idx = 2'd1;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Map interface signals onto per-output arrays; output L never sees backpressure.
  always_comb begin
    req_s[0]  = arb.req_L;
    req_s[1]  = arb.req_N;
    req_s[2]  = arb.req_E;
    req_s[3]  = arb.req_S;
    full_s[0] = 1'b0;
    full_s[1] = arb.N_full;
    full_s[2] = arb.E_full;
    full_s[3] = arb.S_full;
  end

  // Next grant and pointer; an accepted transfer rotates priority at the same edge.
  always_comb begin
    logic       acc_s;
    logic       hold_s;
    logic [1:0] win_s;
    logic [1:0] p_s;
    for (int n = 0; n < 4; n++) begin
      acc_s  = (g_r[n] != 4'b0000) && !full_s[n];
      hold_s = (g_r[n] != 4'b0000) && full_s[n] && ((req_s[n] & g_r[n]) != 4'b0000);
      win_s  = onehot_idx(g_r[n]);
      if (acc_s) begin
        p_s = win_s - 2'd1;
      end else begin
        p_s = ptr_r[n];
      end
      ptr_nxt_s[n] = p_s;
      if (hold_s) begin
        g_nxt_s[n] = g_r[n];
      end else begin
        g_nxt_s[n] = rr_pick(req_s[n], p_s);
      end
    end
  end

  // Grant and pointer registers; reset wins over hold and accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 4; n++) begin
        g_r[n]   <= 4'b0000;
        ptr_r[n] <= RST_PTR;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        g_r[n]   <= g_nxt_s[n];
        ptr_r[n] <= ptr_nxt_s[n];
      end
    end
  end

  assign arb.L_arb_res = g_r[0];
  assign arb.N_arb_res = g_r[1];
  assign arb.E_arb_res = g_r[2];
  assign arb.S_arb_res = g_r[3];

endmodule

// File: tb/tb_switch_rr_arbiter.sv
// Scoreboard bench for switch_rr_arbiter: a behavioural model queues the
// expected grants at each drive, compared one edge later, plus directed checks.
module tb_switch_rr_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  switch_rr_arbiter_if ifc ();

  switch_rr_arbiter #(.NREQ(4), .RST_PTR(2'd3)) dut (
    .clk (clk),
    .rst (rst),
    .arb (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] exp_q [$];
  logic [3:0]  m_g   [4];
  int          m_ptr [4];

  task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] rl, input logic [3:0] rn, input logic [3:0] re,
                        input logic [3:0] rs, input logic fn, input logic fe, input logic fs);
    ifc.req_L  = rl;
    ifc.req_N  = rn;
    ifc.req_E  = re;
    ifc.req_S  = rs;
    ifc.N_full = fn;
    ifc.E_full = fe;
    ifc.S_full = fs;
  endtask

  // Advance the model over the coming edge, queue its prediction, then compare.
  task automatic step();
    logic [3:0]  req_a  [4];
    logic        full_a [4];
    logic [3:0]  ng;
    logic [15:0] e;
    logic [15:0] obs;
    int          win;
    int          p;
    bit          acc;
    req_a[0]  = ifc.req_L;  req_a[1]  = ifc.req_N;
    req_a[2]  = ifc.req_E;  req_a[3]  = ifc.req_S;
    full_a[0] = 1'b0;       full_a[1] = ifc.N_full;
    full_a[2] = ifc.E_full; full_a[3] = ifc.S_full;
    for (int n = 0; n < 4; n++) begin
      if (rst) begin
        m_g[n]   = 4'b0000;
        m_ptr[n] = 3;
      end else begin
        win = 0;
        for (int b = 0; b < 4; b++) if (m_g[n][b]) win = b;
        acc = (m_g[n] != 4'b0000) && !full_a[n];
        p   = acc ? (win + 3) % 4 : m_ptr[n];
        if ((m_g[n] != 4'b0000) && full_a[n] && ((req_a[n] & m_g[n]) != 4'b0000)) begin
          ng = m_g[n];
        end else begin
          ng = 4'b0000;
          for (int k = 0; k < 4; k++) begin
            int b;
            b = (p - k + 4) % 4;
            if (ng == 4'b0000 && req_a[n][b]) ng = 4'(1 << b);
          end
        end
        m_g[n]   = ng;
        m_ptr[n] = p;
      end
    end
    e = {m_g[0], m_g[1], m_g[2], m_g[3]};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    obs = {ifc.L_arb_res, ifc.N_arb_res, ifc.E_arb_res, ifc.S_arb_res};
    check_eq("sb_L", obs[15:12], e[15:12]);
    check_eq("sb_N", obs[11:8],  e[11:8]);
    check_eq("sb_E", obs[7:4],   e[7:4]);
    check_eq("sb_S", obs[3:0],   e[3:0]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] rot_exp [5];
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    set_in(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Reset with random requests, then a single requester on E.
    for (int c = 0; c < 2; c++) begin
      set_in(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b0, 1'b0, 1'b0);
      step();
      check_eq("rst_L", ifc.L_arb_res, 4'b0000);
      check_eq("rst_S", ifc.S_arb_res, 4'b0000);
    end
    rst = 1'b0;
    set_in(4'b0000, 4'b0000, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0);
    step();
    check_eq("first_E", ifc.E_arb_res, 4'b1000);

    // Rotation on N.
    do_reset();
    rot_exp = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    set_in(4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step();
      check_eq("rot_N", ifc.N_arb_res, rot_exp[c]);
    end

    // Hold on full for S, then release.
    do_reset();
    set_in(4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
    step();
    step();
    check_eq("pre_hold_S", ifc.S_arb_res, 4'b0100);
    ifc.S_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check_eq("hold_S", ifc.S_arb_res, 4'b0100);
    end
    ifc.S_full = 1'b0;
    step();
    check_eq("release_S", ifc.S_arb_res, 4'b0010);

    // Request drop while E is full; pointer must stay put.
    do_reset();
    set_in(4'b0000, 4'b0000, 4'b0011, 4'b0000, 1'b0, 1'b1, 1'b0);
    step();
    check_eq("drop_pre_E", ifc.E_arb_res, 4'b0010);
    ifc.req_E = 4'b0001;
    step();
    check_eq("drop_E", ifc.E_arb_res, 4'b0001);
    ifc.req_E = 4'b0000;
    step();
    check_eq("drop_idle_E", ifc.E_arb_res, 4'b0000);
    ifc.req_E  = 4'b1111;
    ifc.E_full = 1'b0;
    step();
    check_eq("drop_ptr_E", ifc.E_arb_res, 4'b1000);

    // Wrap and skip on L.
    do_reset();
    set_in(4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    step();
    check_eq("wrap1_L", ifc.L_arb_res, 4'b1000);
    step();
    check_eq("wrap2_L", ifc.L_arb_res, 4'b0001);
    step();
    check_eq("wrap3_L", ifc.L_arb_res, 4'b1000);
    ifc.req_L = 4'b0000;
    step();
    check_eq("wrap_idle_L", ifc.L_arb_res, 4'b0000);

    // Reset in the middle of traffic.
    do_reset();
    set_in(4'b1111, 4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) step();
    rst = 1'b1;
    step();
    check_eq("mid_rst_N", ifc.N_arb_res, 4'b0000);
    check_eq("mid_rst_E", ifc.E_arb_res, 4'b0000);
    rst = 1'b0;
    set_in(4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    step();
    check_eq("post_rst_N", ifc.N_arb_res, 4'b1000);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      set_in(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
             1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 2) == 0));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
